dw_router_sched: RTL and testbench
==================================

DW_ROUTER_SCHED -- requirements
Module: dw_router_sched

Interface
REQ-001 Parameter POY, default 3, number of parallel output rows (row-buffer banks).
REQ-002 Parameter KSIZE, default 3, depthwise kernel width.
REQ-003 Parameter STRIDE, default 1, horizontal stride; legal values are 1 and 2.
REQ-004 Parameter COLW, default 28, column address width.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port start, input, 1: tile start request; sampled only in IDLE.
REQ-008 Port abort, input, 1: synchronous abort of the tile in progress.
REQ-009 Port stall, input, 1: PE back-pressure; freezes the schedule while high.
REQ-010 Port cfg_w, input, COLW: tile width in columns.
REQ-011 Port cfg_grp, input, 8: number of row groups in the tile.
REQ-012 Port bank, output, 2: active row-buffer bank.
REQ-013 Port row, output, 2: row slot within the bank.
REQ-014 Port col, output, COLW: column read address.
REQ-015 Port rpsel, output, 2: previous bank, equal to (bank+POY-1) mod POY.
REQ-016 Port reg_array_cmd, output, 2: command to the register arrays: 00 HOLD, 01 LOAD_BUF, 10 SHIFT, 11 LOAD_FIFO.
REQ-017 Port fifo_read, output, 1: row-carry FIFO pop strobe.
REQ-018 Port dwpe_ena, output, 1: depthwise PE enable.
REQ-019 Port busy, output, 1: high in every state other than IDLE.
REQ-020 Port done, output, 1: one-cycle pulse when a tile completes.
REQ-021 Port cfg_err, output, 1: one-cycle pulse when start is rejected.

Function
REQ-022 The block SHALL implement the states IDLE, PRELOAD, STREAM, ROWADV and DONE; all outputs SHALL be registered.
REQ-023 In IDLE with start=1, the block SHALL capture cfg_w and cfg_grp and enter PRELOAD if cfg_w>=KSIZE and cfg_grp>=1; otherwise it SHALL pulse cfg_err next cycle and remain in IDLE.
REQ-024 PRELOAD SHALL last KSIZE-1 cycles with col=0..KSIZE-2; cmd SHALL be LOAD_BUF in group 0 and LOAD_FIFO in later groups; dwpe_ena=0.
REQ-025 STREAM SHALL run col=KSIZE-1..cfg_w-1, one column per cycle, with cmd SHIFT.
REQ-026 In STREAM, dwpe_ena SHALL be 1 exactly when (col-(KSIZE-1)) mod STRIDE = 0.
REQ-027 At the last STREAM column, the block SHALL go to ROWADV if groups remain, otherwise to DONE.
REQ-028 ROWADV SHALL last 1 cycle with fifo_read=1 and cmd HOLD; it SHALL then set bank to (bank+1) mod POY, row to (row+1) mod 4 and col to 0, and enter PRELOAD.
REQ-029 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-030 While stall=1 outside IDLE, state, col, bank, row and group count SHALL hold, with dwpe_ena=0, fifo_read=0 and cmd HOLD.
REQ-031 Abort outside IDLE SHALL force IDLE on the next cycle with done=0, and abort SHALL take priority over stall.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 The col counter SHALL never exceed cfg_w-1, and the group counter SHALL be 8 bits with no wrap.
REQ-034 The block SHALL take cfg_w+1 cycles per non-final group and cfg_w cycles for the final group, plus one DONE cycle.

Reset
REQ-035 On rst the block SHALL enter IDLE immediately and set bank=0, row=0, col=0, rpsel=POY-1, cmd=HOLD, and fifo_read, dwpe_ena, busy, done and cfg_err all to 0.
REQ-036 Reset asserted mid-tile SHALL discard the tile with no done pulse.

Structure
REQ-037 The reg_array_cmd encodings and the FSM state enum SHALL live in the shared package dw_router_pkg, which the register-array datapath also imports.
REQ-038 The block SHALL have one sub-module, dw_col_cnt: a loadable column counter with stall-hold and terminal-count flag.

Verification
REQ-039 Scenario, nominal tile: KSIZE=3, STRIDE=1, cfg_w=8, cfg_grp=2, start sampled at cycle 0 -> PRELOAD at cycles 1-2, STREAM at 3-8, ROWADV at 9 (fifo_read), PRELOAD at 10-11 (LOAD_FIFO), STREAM at 12-17, done at 18; 12 dwpe_ena pulses in total; bank 0 then 1.
REQ-040 Scenario, stride 2: STRIDE=2, cfg_w=8, cfg_grp=1 -> dwpe_ena at col 2, 4 and 6 only (3 pulses).
REQ-041 Scenario, stall: stall high for 4 cycles during STREAM at col=5 -> col holds at 5, dwpe_ena=0, and completion is delayed by exactly 4 cycles.
REQ-042 Scenario, bad config: cfg_w=2 or cfg_grp=0 with start -> cfg_err pulse, busy stays 0.
REQ-043 Scenario, bank wrap: cfg_grp=4, POY=3 -> bank sequence 0,1,2,0 and rpsel sequence 2,0,1,2.
REQ-044 Scenario, abort and reset: abort at cycle 5, then rst mid-tile -> IDLE next cycle, no done, all outputs at their reset values.

Source files
------------

// File: rtl/dw_router_pkg.sv
// Shared types for the depthwise row router: scheduler states, register-array
// commands and the registered control bundle driven toward the PE datapath.
package dw_router_pkg;

  localparam int unsigned GRP_W  = 8;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned ROW_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_STREAM  = 3'd2,
    ST_ROWADV  = 3'd3,
    ST_DONE    = 3'd4
  } sched_state_e;

  typedef enum logic [1:0] {
    CMD_HOLD      = 2'b00,
    CMD_LOAD_BUF  = 2'b01,
    CMD_SHIFT     = 2'b10,
    CMD_LOAD_FIFO = 2'b11
  } ra_cmd_e;

  typedef struct packed {
    logic    fifo_read;
    logic    dwpe_ena;
    logic    done;
    ra_cmd_e cmd;
  } sched_ctl_t;

  // Modulo-POY bank stepping; last is POY-1.
  function automatic logic [BANK_W-1:0] bank_step(input logic [BANK_W-1:0] b,
                                                  input logic [BANK_W-1:0] last);
    return (b == last) ? BANK_W'(0) : b + BANK_W'(1);
  endfunction

  function automatic logic [BANK_W-1:0] bank_prev(input logic [BANK_W-1:0] b,
                                                  input logic [BANK_W-1:0] last);
    return (b == BANK_W'(0)) ? last : b - BANK_W'(1);
  endfunction

endpackage

// File: rtl/dw_col_cnt.sv
// Loadable column counter: clear, increment with stall hold, saturating at
// the programmed last column and flagging it as terminal count.
module dw_col_cnt #(
  parameter int unsigned COLW = 28
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  input  logic            hold,
  input  logic [COLW-1:0] last,
  output logic [COLW-1:0] cnt,
  output logic [COLW-1:0] cnt_nxt_c,
  output logic            tc_c
);

  logic [COLW-1:0] cnt_q;
  logic [COLW-1:0] cnt_d;

  assign tc_c = (cnt_q == last);

  // Never step past the last column, even if asked to.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !hold && !tc_c) begin
      cnt_d = cnt_q + COLW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign cnt_nxt_c = cnt_d;

endmodule

// File: rtl/dw_router_sched.sv
// Depthwise row-buffer router scheduler: walks columns of each row group,
// sequencing register-array loads, shifts, PE enables and bank rotation.
module dw_router_sched
  import dw_router_pkg::*;
#(
  parameter int unsigned POY    = 3,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned COLW   = 28
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            stall,
  input  logic [COLW-1:0] cfg_w,
  input  logic [7:0]      cfg_grp,
  output logic [1:0]      bank,
  output logic [1:0]      row,
  output logic [COLW-1:0] col,
  output logic [1:0]      rpsel,
  output logic [1:0]      reg_array_cmd,
  output logic            fifo_read,
  output logic            dwpe_ena,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(POY - 1);
  localparam logic [COLW-1:0]   KSIZE_C   = COLW'(KSIZE);
  localparam logic [COLW-1:0]   PRE_LAST  = COLW'((KSIZE > 1) ? KSIZE - 2 : 0);
  localparam logic              PHASE     = 1'((KSIZE - 1) % 2);
  localparam sched_state_e      FIRST_ST  = (KSIZE > 1) ? ST_PRELOAD : ST_STREAM;

  sched_state_e      state_q, state_d;
  logic [COLW-1:0]   w_q, w_d;
  logic [GRP_W-1:0]  grp_tot_q, grp_tot_d;
  logic [GRP_W-1:0]  grp_idx_q, grp_idx_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BANK_W-1:0] rpsel_q, rpsel_d;
  sched_ctl_t        ctl_q, ctl_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              abort_c;
  logic              stall_hold_c;
  logic              last_grp_c;
  logic              col_clr_c;
  logic              col_inc_c;
  logic [COLW-1:0]   col_q;
  logic [COLW-1:0]   col_nxt_c;
  logic              col_tc_c;
  logic [COLW-1:0]   w_last_c;

  assign abort_c      = abort && (state_q != ST_IDLE);
  assign stall_hold_c = stall && (state_q != ST_IDLE) && !abort;
  assign last_grp_c   = (grp_idx_q == grp_tot_q - GRP_W'(1));
  assign w_last_c     = w_q - COLW'(1);

  dw_col_cnt #(
    .COLW(COLW)
  ) u_col_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (col_clr_c),
    .inc       (col_inc_c),
    .hold      (stall_hold_c),
    .last      (w_last_c),
    .cnt       (col_q),
    .cnt_nxt_c (col_nxt_c),
    .tc_c      (col_tc_c)
  );

  // Next-state: abort wins over stall; stall freezes every counter.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    grp_tot_d = grp_tot_q;
    grp_idx_d = grp_idx_q;
    bank_d    = bank_q;
    row_d     = row_q;
    col_clr_c = 1'b0;
    col_inc_c = 1'b0;
    err_d     = 1'b0;
    if (abort_c) begin
      state_d   = ST_IDLE;
      bank_d    = '0;
      row_d     = '0;
      col_clr_c = 1'b1;
    end else if (!stall_hold_c) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if ((cfg_w >= KSIZE_C) && (cfg_grp != '0)) begin
              w_d       = cfg_w;
              grp_tot_d = cfg_grp;
              grp_idx_d = '0;
              state_d   = FIRST_ST;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_PRELOAD: begin
          col_inc_c = 1'b1;
          if (col_q == PRE_LAST) begin
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (col_tc_c) begin
            state_d = last_grp_c ? ST_DONE : ST_ROWADV;
          end else begin
            col_inc_c = 1'b1;
          end
        end
        ST_ROWADV: begin
          bank_d    = bank_step(bank_q, BANK_LAST);
          row_d     = row_q + ROW_W'(1);
          grp_idx_d = grp_idx_q + GRP_W'(1);
          col_clr_c = 1'b1;
          state_d   = FIRST_ST;
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          bank_d    = '0;
          row_d     = '0;
          col_clr_c = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode for the upcoming cycle; a stalled cycle is a pure bubble.
  always_comb begin
    ctl_d.fifo_read = 1'b0;
    ctl_d.dwpe_ena  = 1'b0;
    ctl_d.done      = 1'b0;
    ctl_d.cmd       = CMD_HOLD;
    busy_d          = (state_d != ST_IDLE);
    rpsel_d         = bank_prev(bank_d, BANK_LAST);
    if (!stall_hold_c) begin
      case (state_d)
        ST_PRELOAD: ctl_d.cmd = (grp_idx_d == '0) ? CMD_LOAD_BUF : CMD_LOAD_FIFO;
        ST_STREAM: begin
          ctl_d.cmd      = CMD_SHIFT;
          ctl_d.dwpe_ena = (STRIDE == 1) || (col_nxt_c[0] == PHASE);
        end
        ST_ROWADV:  ctl_d.fifo_read = 1'b1;
        ST_DONE:    ctl_d.done      = 1'b1;
        default:    ctl_d.cmd       = CMD_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      grp_tot_q <= '0;
      grp_idx_q <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      rpsel_q   <= BANK_LAST;
      ctl_q     <= '{fifo_read: 1'b0, dwpe_ena: 1'b0, done: 1'b0, cmd: CMD_HOLD};
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      grp_tot_q <= grp_tot_d;
      grp_idx_q <= grp_idx_d;
      bank_q    <= bank_d;
      row_q     <= row_d;
      rpsel_q   <= rpsel_d;
      ctl_q     <= ctl_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bank          = bank_q;
  assign row           = row_q;
  assign col           = col_q;
  assign rpsel         = rpsel_q;
  assign reg_array_cmd = ctl_q.cmd;
  assign fifo_read     = ctl_q.fifo_read;
  assign dwpe_ena      = ctl_q.dwpe_ena;
  assign busy          = busy_q;
  assign done          = ctl_q.done;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_dw_router_sched.sv
// Bench for dw_router_sched: a stride-1 and a stride-2 instance share stimulus
// and are compared every cycle against a slot-list schedule model.
module tb_dw_router_sched;

  localparam int unsigned POY  = 3;
  localparam int unsigned COLW = 28;
  localparam int          KS   = 3;

  typedef struct packed {
    logic [1:0]      bank;
    logic [1:0]      row;
    logic [1:0]      cmd;
    logic [COLW-1:0] col;
    logic            dw1;
    logic            dw2;
    logic            fifo;
    logic            done;
    logic            busy;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, abort, stall;
  logic [COLW-1:0] cfg_w;
  logic [7:0]      cfg_grp;

  logic [1:0] bank_a, row_a, rpsel_a, cmd_a, bank_b, row_b, rpsel_b, cmd_b;
  logic [COLW-1:0] col_a, col_b;
  logic fifo_a, dwpe_a, busy_a, done_a, err_a;
  logic fifo_b, dwpe_b, busy_b, done_b, err_b;

  always #5 clk = ~clk;

  dw_router_sched #(.POY(POY), .KSIZE(KS), .STRIDE(1), .COLW(COLW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .cfg_w(cfg_w), .cfg_grp(cfg_grp), .bank(bank_a), .row(row_a), .col(col_a),
    .rpsel(rpsel_a), .reg_array_cmd(cmd_a), .fifo_read(fifo_a), .dwpe_ena(dwpe_a),
    .busy(busy_a), .done(done_a), .cfg_err(err_a));

  dw_router_sched #(.POY(POY), .KSIZE(KS), .STRIDE(2), .COLW(COLW)) u_dut_s2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .cfg_w(cfg_w), .cfg_grp(cfg_grp), .bank(bank_b), .row(row_b), .col(col_b),
    .rpsel(rpsel_b), .reg_array_cmd(cmd_b), .fifo_read(fifo_b), .dwpe_ena(dwpe_b),
    .busy(busy_b), .done(done_b), .cfg_err(err_b));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  exp_t sched[$];
  int   idx;
  bit   in_tile = 1'b0;
  exp_t cur;
  int   p1, p2, n_done, done_at, t0;
  int   bank_log[$];
  int   rp_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    return e;
  endfunction

  // Expected output slots of one tile, written straight from the schedule rules.
  task automatic build_sched(input int w, input int g);
    exp_t s;
    int bk, rw;
    sched.delete();
    bk = 0;
    rw = 0;
    for (int gi = 0; gi < g; gi++) begin
      for (int c = 0; c < w; c++) begin
        s = '0;
        s.bank = 2'(bk); s.row = 2'(rw); s.col = COLW'(c); s.busy = 1'b1;
        if (c < KS - 1) begin
          s.cmd = (gi == 0) ? 2'b01 : 2'b11;
        end else begin
          s.cmd = 2'b10;
          s.dw1 = 1'b1;
          s.dw2 = (((c - KS + 1) % 2) == 0);
        end
        sched.push_back(s);
      end
      s = '0;
      s.bank = 2'(bk); s.row = 2'(rw); s.col = COLW'(w - 1); s.busy = 1'b1;
      if (gi < g - 1) begin
        s.fifo = 1'b1;
        sched.push_back(s);
        bk = (bk + 1) % POY;
        rw = (rw + 1) % 4;
      end else begin
        s.done = 1'b1;
        sched.push_back(s);
      end
    end
  endtask

  function automatic exp_t bubble(input exp_t s);
    exp_t e;
    e = s;
    e.cmd = 2'b00; e.dw1 = 1'b0; e.dw2 = 1'b0; e.fifo = 1'b0; e.done = 1'b0;
    return e;
  endfunction

  task automatic model_step(input bit st, input bit ab, input bit sl);
    cur = idle_exp();
    if (!in_tile) begin
      if (st) begin
        if (int'(cfg_w) >= KS && cfg_grp >= 8'd1) begin
          build_sched(int'(cfg_w), int'(cfg_grp));
          idx = 0;
          in_tile = 1'b1;
          cur = sched[0];
        end else begin
          cur.err = 1'b1;
        end
      end
    end else if (ab) begin
      in_tile = 1'b0;
    end else if (sl) begin
      cur = bubble(sched[idx]);
    end else begin
      idx++;
      if (idx >= sched.size()) in_tile = 1'b0;
      else cur = sched[idx];
    end
  endtask

  task automatic check_all();
    logic [1:0] rp;
    rp = 2'((int'(cur.bank) + POY - 1) % POY);
    chk("bank_row_rpsel_cmd", 64'({bank_a, row_a, rpsel_a, cmd_a}), 64'({cur.bank, cur.row, rp, cur.cmd}));
    chk("col", 64'(col_a), 64'(cur.col));
    chk("flags", 64'({fifo_a, dwpe_a, busy_a, done_a, err_a}),
        64'({cur.fifo, cur.dw1, cur.busy, cur.done, cur.err}));
    chk("s2_outputs",
        64'({bank_b, row_b, rpsel_b, cmd_b, col_b, fifo_b, dwpe_b, busy_b, done_b, err_b}),
        64'({cur.bank, cur.row, rp, cur.cmd, cur.col, cur.fifo, cur.dw2, cur.busy, cur.done, cur.err}));
  endtask

  task automatic cycle(input bit st, input bit ab, input bit sl);
    start = st; abort = ab; stall = sl;
    @(posedge clk);
    #1;
    cyc++;
    model_step(st, ab, sl);
    check_all();
    p1 += int'(dwpe_a);
    p2 += int'(dwpe_b);
    if (done_a) begin
      n_done++;
      done_at = cyc;
    end
    if ((cmd_a == 2'b01 || cmd_a == 2'b11) && col_a == '0) begin
      bank_log.push_back(int'(bank_a));
      rp_log.push_back(int'(rpsel_a));
    end
    start = 1'b0; abort = 1'b0; stall = 1'b0;
  endtask

  task automatic begin_tile(input int w, input int g);
    p1 = 0; p2 = 0; n_done = 0; done_at = -1;
    bank_log.delete();
    rp_log.delete();
    cfg_w = COLW'(w);
    cfg_grp = 8'(g);
    cycle(1'b1, 1'b0, 1'b0);
    t0 = cyc - 1;
  endtask

  task automatic run_to_idle(input int max);
    int n;
    n = 0;
    while (busy_a && n < max) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("idle_timeout", 64'(busy_a), 64'(0));
  endtask

  int exp_bank[4] = '{0, 1, 2, 0};
  int exp_rp[4]   = '{2, 0, 1, 2};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    cfg_w = '0; cfg_grp = '0;
    repeat (2) @(posedge clk);
    #1;
    cur = idle_exp();
    check_all();
    rst = 1'b0;

    // Nominal two-group tile.
    begin_tile(8, 2);
    run_to_idle(64);
    chk("nom_done_cycle", 64'(done_at - t0), 64'(18));
    chk("nom_pulses_s1", 64'(p1), 64'(12));
    chk("nom_pulses_s2", 64'(p2), 64'(6));
    chk("nom_bank_cnt", 64'(bank_log.size()), 64'(2));
    if (bank_log.size() == 2) chk("nom_bank_seq", 64'({bank_log[0], bank_log[1]}), 64'({32'd0, 32'd1}));

    // Single group; stride-2 instance fires at cols 2, 4, 6.
    begin_tile(8, 1);
    run_to_idle(64);
    chk("s2_pulses", 64'(p2), 64'(3));
    chk("s1_pulses_single", 64'(p1), 64'(6));
    chk("single_done_cycle", 64'(done_at - t0), 64'(9));

    // Stall four cycles at col 5.
    begin_tile(8, 1);
    for (int n = 0; n < 20 && !(col_a == COLW'(5) && cmd_a == 2'b10); n++) cycle(1'b0, 1'b0, 1'b0);
    chk("stall_reach_col5", 64'(col_a), 64'(5));
    for (int n = 0; n < 4; n++) begin
      cycle(1'b0, 1'b0, 1'b1);
      chk("stall_col_hold", 64'({col_a, dwpe_a}), 64'({COLW'(5), 1'b0}));
    end
    run_to_idle(64);
    chk("stall_done_cycle", 64'(done_at - t0), 64'(13));

    // Rejected configurations.
    begin_tile(2, 1);
    chk("bad_w_err", 64'({err_a, busy_a}), 64'({1'b1, 1'b0}));
    cycle(1'b0, 1'b0, 1'b0);
    chk("bad_w_pulse_end", 64'(err_a), 64'(0));
    begin_tile(8, 0);
    chk("bad_grp_err", 64'({err_a, busy_a}), 64'({1'b1, 1'b0}));

    // Bank and rpsel rotation over four groups.
    begin_tile(4, 4);
    run_to_idle(64);
    chk("wrap_cnt", 64'(bank_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < bank_log.size(); i++) begin
      chk("wrap_bank", 64'(bank_log[i]), 64'(exp_bank[i]));
      chk("wrap_rpsel", 64'(rp_log[i]), 64'(exp_rp[i]));
    end

    // Abort at cycle 5, then reset mid-tile.
    begin_tile(8, 2);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("abort_idle", 64'({busy_a, done_a}), 64'(0));
    begin_tile(8, 2);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    in_tile = 1'b0;
    cur = idle_exp();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    chk("abort_rst_no_done", 64'(n_done), 64'(0));

    // Randomized traffic, including starts while busy and config churn.
    for (int n = 0; n < 3000; n++) begin
      cfg_w = COLW'($urandom_range(1, 12));
      cfg_grp = 8'($urandom_range(0, 4));
      cycle(($urandom % 4) == 0, ($urandom % 40) == 0, ($urandom % 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d obs=running exp=finished", cyc);
    $fatal(1);
  end

endmodule
